// File: rtl/mux_arb_pkg.sv
// Shared types and burst constants for the round-robin read-mux arbiter.
package mux_arb_pkg;

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam int MAX_BURST = 4;
  localparam int LEN_W     = $clog2(MAX_BURST);

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin picker: first set request after last_i, wrapping modulo N_REQ.
module rr_arbiter_n #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  int               sum;
  logic [IDX_W-1:0] idx;

  // Scan farthest-to-nearest so the closest requester after last_i overwrites the rest.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    sum       = 0;
    idx       = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      sum = int'(last_i) + off;
      if (sum >= N_REQ) sum = sum - N_REQ;
      idx = IDX_W'(sum);
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/mux_read_arbiter.sv
// Round-robin sharing of one combinational read mux; bursts of 1-4 consecutive words per grant.
module mux_read_arbiter
  import mux_arb_pkg::*;
#(
  parameter int n       = 4,
  parameter int address = 11,
  parameter int N_REQ   = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [N_REQ-1:0]                  req_valid_i,
  input  logic [0:N_REQ-1][address-1:0]     req_addr_i,
  input  logic [0:N_REQ-1][1:0]             req_len_i,
  output logic [N_REQ-1:0]                  req_ready_o,
  output logic [address-1:0]                mux_sel_o,
  input  logic [n-1:0]                      mux_data_i,
  output logic [N_REQ-1:0]                  rsp_valid_o,
  output logic [n-1:0]                      rsp_data_o,
  output logic                              rsp_last_o,
  output logic                              busy_o
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t             state_q;
  logic [IDX_W-1:0]   grant_id_q;
  logic [IDX_W-1:0]   last_grant_q;
  logic [address-1:0] cur_addr_q;
  logic [address-1:0] cur_addr_d;
  logic [LEN_W-1:0]   beats_left_q;
  logic [N_REQ-1:0]   rsp_valid_q;
  logic [N_REQ-1:0]   rsp_valid_d;
  logic [n-1:0]       rsp_data_q;
  logic               rsp_last_q;

  logic [N_REQ-1:0]   gnt;
  logic [IDX_W-1:0]   gnt_idx;

  rr_arbiter_n #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i     (req_valid_i),
    .last_i    (last_grant_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  // Grants are only offered in IDLE and never while reset is held.
  assign req_ready_o = (state_q == IDLE && rst_ni) ? gnt : '0;
  assign mux_sel_o   = cur_addr_q;
  assign busy_o      = (state_q == ISSUE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_last_o  = rsp_last_q;

  assign cur_addr_d  = cur_addr_q + address'(1);
  assign rsp_valid_d = N_REQ'(1) << grant_id_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_last_q   <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      rsp_last_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_ready_o) begin
            grant_id_q   <= gnt_idx;
            last_grant_q <= gnt_idx;
            cur_addr_q   <= req_addr_i[gnt_idx];
            beats_left_q <= req_len_i[gnt_idx];
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_data_q  <= mux_data_i;
          rsp_valid_q <= rsp_valid_d;
          rsp_last_q  <= (beats_left_q == '0);
          cur_addr_q  <= cur_addr_d;
          if (beats_left_q == '0) state_q <= IDLE;
          else beats_left_q <= beats_left_q - LEN_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mux_read_arbiter.md
Name: mux_read_arbiter

Overview:
- Shares one large combinational read-select path (the mux2048to1_n word selector over a 2048-entry, n-bit array) between N_REQ requesters.
- Round-robin arbitration; each request is a burst of 1-4 words at consecutive addresses.
- The block drives the mux select and registers the mux output into a per-requester response stream.
- Sits between the core's read clients (fetch, load, debug) and the shared ROM/RAM read mux.

Parameters:
- n, 4, data word width, matching the mux data width.
- address, 11, select width; array depth m = 2**address.
- N_REQ, 4, number of requesters (2..8).

Ports:
- clk_i, input, 1: single clock, all state on the rising edge.
- rst_ni, input, 1: reset, synchronous, active-low.
- req_valid_i, input, [N_REQ-1:0]: request pending, one bit per requester.
- req_addr_i, input, [0:N_REQ-1][address-1:0]: burst start address per requester.
- req_len_i, input, [0:N_REQ-1][1:0]: beats minus 1 (0 means 1 word, 3 means 4 words).
- req_ready_o, output, [N_REQ-1:0]: one-hot grant; a handshake occurs when valid and ready are both 1.
- mux_sel_o, output, [address-1:0]: select to the mux.
- mux_data_i, input, [n-1:0]: mux data_o, combinational from mux_sel_o.
- rsp_valid_o, output, [N_REQ-1:0]: one-hot; this requester's word is on rsp_data_o.
- rsp_data_o, output, [n-1:0]: registered read word (shared bus).
- rsp_last_o, output, 1: final beat of the burst.
- busy_o, output, 1: burst in progress.

Behaviour:
- States: IDLE, ISSUE. Registers: state, grant_id, cur_addr, beats_left[1:0], last_grant.
- Reset (rst_ni=0 at an edge): state=IDLE, last_grant=N_REQ-1 (so requester 0 wins first), cur_addr=0, grant_id=0.
- Output values after reset: rsp_valid_o=0, rsp_data_o=0, rsp_last_o=0, busy_o=0, mux_sel_o=0, req_ready_o=0 while rst_ni=0.
- IDLE:
  - req_ready_o is combinational: one-hot of the first set req_valid_i bit searching from last_grant+1 upward, modulo N_REQ.
  - req_ready_o=0 if no request is valid.
  - On handshake: grant_id<=winner, last_grant<=winner, cur_addr<=req_addr_i[winner], beats_left<=req_len_i[winner], state<=ISSUE.
- ISSUE:
  - req_ready_o=0 and busy_o=1. mux_sel_o=cur_addr.
  - Every cycle: rsp_data_o<=mux_data_i, rsp_valid_o<=onehot(grant_id), rsp_last_o<=(beats_left==0), cur_addr<=cur_addr+1 (wraps 2**address-1 to 0).
  - If beats_left==0, state<=IDLE; otherwise beats_left<=beats_left-1.
- Timing:
  - Handshake in cycle T: first word valid in T+2, beat k valid in T+2+k, no gaps.
  - The requester must accept responses unconditionally; there is no response backpressure.
- Throughput: the IDLE cycle after each burst is a mandatory bubble. A new handshake is possible in the cycle after the last ISSUE cycle.
- mux_sel_o in IDLE holds the last cur_addr value (already incremented); it carries no meaning in IDLE.
- Outside a response beat: rsp_valid_o=0, rsp_last_o=0, rsp_data_o holds its last value.
- A requester deasserting valid without a handshake is legal and has no effect. Requests arriving during ISSUE wait; their addr/len are sampled only at handshake.
- Reset mid-burst: the burst is aborted. rsp_valid_o=0 from the cycle after the reset edge. No resume; the requester reissues.

Decomposition:
- Package mux_arb_pkg:
  - state_t enum {IDLE, ISSUE}.
  - MAX_BURST=4 and LEN_W=2 constants.
- Sub-module rr_arbiter_n#(N_REQ):
  - Inputs: request vector and last_grant pointer.
  - Outputs: combinational one-hot grant and its binary index.
  - Reusable by other shared resources.

Test Plan:
- Single read: mem[0x005]=4'hA; req 0, addr 0x005, len 0 handshake at T -> T+2 rsp_valid_o=4'b0001, rsp_data_o=A, rsp_last_o=1; busy_o high only in T+1.
- Burst with wrap: req 2, addr 0x7FE, len 3 -> mux_sel_o 0x7FE, 0x7FF, 0x000, 0x001 in T+1..T+4; four beats T+2..T+5, rsp_last_o only on the 4th.
- Contention: req 1 and 3 valid simultaneously after reset -> 1 granted first, then 3 in the IDLE slot after 1's burst; req 1 re-requesting is not granted before 3.
- Full load: all 4 requesters continuously valid with len 0 -> grant order 0, 1, 2, 3, 0, 1; one grant every 2 cycles.
- Reset mid-burst: rst_ni=0 for one edge during beat 2 of a 4-beat burst -> no further rsp_valid_o; busy_o=0; the next grant starts from requester 0.
- Hold while busy: req 0 valid with addr 0x100 during another burst, addr changed to 0x200 before grant -> the burst reads from 0x200.
